// File: rtl/scan2bus.sv
// rtl/scan2bus.sv - reassembles a scanned 8-slot digit stream into a confirmed hh:mm:ss binary bus
module scan2bus #(
  parameter int CONFIRM = 2
) (
  input  logic        clk1000,
  input  logic        rst,
  input  logic [3:0]  num,
  input  logic [7:0]  wx,
  output logic [23:0] bus,
  output logic        bus_vld,
  output logic        locked,
  output logic        frm_err
);

  localparam logic [2:0] CONF = 3'(CONFIRM);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t      state;
  logic [2:0]  exp_slot;
  logic [3:0]  d0, d1, d3, d4, d6;
  logic [2:0]  match;
  logic [23:0] prev_val;

  logic        wx_ok;
  logic [2:0]  slot;
  logic        dig_ok;
  logic [7:0]  hours;
  logic        hours_ok;
  logic [23:0] frame_val;
  logic        same;
  logic [2:0]  new_cnt;
  logic        load;

  function automatic logic [7:0] bcd(input logic [3:0] t, input logic [3:0] u);
    return ({4'd0, t} << 3) + ({4'd0, t} << 1) + {4'd0, u};
  endfunction

  // One-cold select: the single low bit at position p names slot 7-p.
  always_comb begin
    slot  = 3'd0;
    wx_ok = ($countones(~wx) == 1);
    for (int i = 0; i < 8; i++) begin
      if (!wx[i]) slot = 3'(7 - i);
    end
  end

  always_comb begin
    dig_ok = 1'b0;
    case (slot)
      3'd0:       dig_ok = (num <= 4'd2);
      3'd2, 3'd5: dig_ok = (num == 4'hF);
      3'd3, 3'd6: dig_ok = (num <= 4'd5);
      default:    dig_ok = (num <= 4'd9);
    endcase
  end

  // Slot 7 is never stored; the live sample supplies the last seconds digit.
  always_comb begin
    hours     = bcd(d0, d1);
    hours_ok  = (hours <= 8'd23);
    frame_val = {hours, bcd(d3, d4), bcd(d6, num)};
    same      = (frame_val == prev_val);
    if (same) new_cnt = (match == CONF) ? CONF : match + 3'd1;
    else      new_cnt = 3'd1;
    load      = (new_cnt == CONF) && ((match != CONF) || (frame_val != bus));
  end

  always_ff @(posedge clk1000) begin
    if (rst) begin
      state    <= HUNT;
      exp_slot <= 3'd0;
      d0       <= 4'd0;
      d1       <= 4'd0;
      d3       <= 4'd0;
      d4       <= 4'd0;
      d6       <= 4'd0;
      match    <= 3'd0;
      prev_val <= 24'h000000;
      bus      <= 24'h000000;
      bus_vld  <= 1'b0;
      locked   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      bus_vld <= 1'b0;
      frm_err <= 1'b0;
      case (state)
        HUNT: begin
          if (wx_ok && slot == 3'd0) begin
            if (dig_ok) begin
              d0       <= num;
              exp_slot <= 3'd1;
              state    <= COLLECT;
            end else begin
              frm_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (wx_ok && slot == exp_slot && dig_ok) begin
            case (exp_slot)
              3'd1:    d1 <= num;
              3'd3:    d3 <= num;
              3'd4:    d4 <= num;
              3'd6:    d6 <= num;
              default: ;
            endcase
            if (exp_slot == 3'd7) begin
              state <= HUNT;
              if (hours_ok) begin
                prev_val <= frame_val;
                match    <= new_cnt;
                locked   <= (new_cnt == CONF);
                if (load) begin
                  bus     <= frame_val;
                  bus_vld <= 1'b1;
                end
              end else begin
                frm_err <= 1'b1;
                locked  <= 1'b0;
                match   <= 3'd0;
              end
            end else begin
              exp_slot <= exp_slot + 3'd1;
            end
          end else begin
            frm_err <= 1'b1;
            locked  <= 1'b0;
            match   <= 3'd0;
            // A legal slot 0 that breaks a frame opens the next one immediately.
            if (wx_ok && slot == 3'd0 && dig_ok) begin
              d0       <= num;
              exp_slot <= 3'd1;
            end else begin
              state <= HUNT;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_scan2bus.sv
// tb/tb_scan2bus.sv - table-driven bench for scan2bus with hand-computed expectations
module tb_scan2bus;

  logic        clk1000 = 1'b0;
  logic        rst;
  logic [3:0]  num;
  logic [7:0]  wx;
  logic [23:0] bus;
  logic        bus_vld;
  logic        locked;
  logic        frm_err;

  int tests  = 0;
  int failed = 0;

  scan2bus #(.CONFIRM(2)) dut (
    .clk1000 (clk1000),
    .rst     (rst),
    .num     (num),
    .wx      (wx),
    .bus     (bus),
    .bus_vld (bus_vld),
    .locked  (locked),
    .frm_err (frm_err)
  );

  always #5 clk1000 = ~clk1000;

  typedef struct {
    logic        rst;
    logic [7:0]  wx;
    logic [3:0]  num;
    logic [23:0] bus;
    logic        vld;
    logic        lock;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] sel(input int k);
    return 8'hFF ^ (8'h80 >> k);
  endfunction

  task automatic add(input logic r, input logic [7:0] w, input logic [3:0] n,
                     input logic [23:0] b, input logic v, input logic l, input logic e);
    vec_t t;
    t.rst = r; t.wx = w; t.num = n; t.bus = b; t.vld = v; t.lock = l; t.err = e;
    vq.push_back(t);
  endtask

  // digs holds slot 0 in the top nibble; err_slot = -1 for a clean frame.
  task automatic add_slots(input logic [31:0] digs, input int from, input int to,
                           input int err_slot, input logic [23:0] b_mid, input logic l_mid,
                           input logic [23:0] b_end, input logic v_end, input logic l_end);
    for (int k = from; k <= to; k++) begin
      logic [3:0] n;
      n = 4'(digs >> (28 - 4 * k));
      if (k == 7 && err_slot != 7)
        add(1'b0, sel(k), n, b_end, v_end, l_end, 1'b0);
      else
        add(1'b0, sel(k), n, b_mid, 1'b0,
            (err_slot >= 0 && k >= err_slot) ? 1'b0 : l_mid, (k == err_slot));
    end
  endtask

  task automatic frame(input logic [31:0] digs, input int err_slot,
                       input logic [23:0] b_mid, input logic l_mid,
                       input logic [23:0] b_end, input logic v_end, input logic l_end);
    add_slots(digs, 0, 7, err_slot, b_mid, l_mid, b_end, v_end, l_end);
  endtask

  task automatic chk(input string name, input int idx, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wx  = 8'hFF;
    num = 4'd0;

    // reset
    add(1'b1, 8'hFF, 4'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 4'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    // nominal lock at 12:34:56
    frame(32'h12F34F56, -1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(32'h12F34F56, -1, 24'h0, 1'b0, 24'h0C2238, 1'b1, 1'b1);
    // value change to 12:34:57, then steady state
    frame(32'h12F34F57, -1, 24'h0C2238, 1'b1, 24'h0C2238, 1'b0, 1'b0);
    frame(32'h12F34F57, -1, 24'h0C2238, 1'b0, 24'h0C2239, 1'b1, 1'b1);
    frame(32'h12F34F57, -1, 24'h0C2239, 1'b1, 24'h0C2239, 1'b0, 1'b1);
    // illegal digits: minutes tens 6, bad separator, hours 24
    frame(32'h12F64F57, 3, 24'h0C2239, 1'b1, 24'h0C2239, 1'b0, 1'b0);
    frame(32'h12734F57, 2, 24'h0C2239, 1'b0, 24'h0C2239, 1'b0, 1'b0);
    frame(32'h24F00F00, 7, 24'h0C2239, 1'b0, 24'h0C2239, 1'b0, 1'b0);
    // out-of-order restart on slot 0, then 23:59:59 twice
    add_slots(32'h12F34F56, 0, 2, -1, 24'h0C2239, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(32'h23F59F59, 0, 24'h0C2239, 1'b0, 24'h0C2239, 1'b0, 1'b0);
    frame(32'h23F59F59, -1, 24'h0C2239, 1'b0, 24'h173B3B, 1'b1, 1'b1);
    // corrupt select in slot 4, then all-ones select in HUNT
    add_slots(32'h23F59F59, 0, 3, -1, 24'h173B3B, 1'b1, 24'h0, 1'b0, 1'b0);
    add(1'b0, 8'hE7, 4'd5, 24'h173B3B, 1'b0, 1'b0, 1'b1);
    add_slots(32'h23F59F59, 5, 7, 4, 24'h173B3B, 1'b0, 24'h173B3B, 1'b0, 1'b0);
    add(1'b0, 8'hFF, 4'd0, 24'h173B3B, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'hFF, 4'd9, 24'h173B3B, 1'b0, 1'b0, 1'b0);
    frame(32'h23F59F59, -1, 24'h173B3B, 1'b0, 24'h173B3B, 1'b0, 1'b0);
    frame(32'h23F59F59, -1, 24'h173B3B, 1'b0, 24'h173B3B, 1'b1, 1'b1);
    // reset after slot 5; stray slots 6,7 must be ignored in HUNT
    add_slots(32'h12F34F56, 0, 5, -1, 24'h173B3B, 1'b1, 24'h0, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 4'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    add_slots(32'h12F34F56, 6, 7, -1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(32'h12F34F56, -1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
    frame(32'h12F34F56, -1, 24'h0, 1'b0, 24'h0C2238, 1'b1, 1'b1);

    foreach (vq[i]) begin
      rst = vq[i].rst;
      wx  = vq[i].wx;
      num = vq[i].num;
      @(posedge clk1000);
      #1;
      chk("bus",     i, bus,              vq[i].bus);
      chk("bus_vld", i, {23'd0, bus_vld}, {23'd0, vq[i].vld});
      chk("locked",  i, {23'd0, locked},  {23'd0, vq[i].lock});
      chk("frm_err", i, {23'd0, frm_err}, {23'd0, vq[i].err});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
